memory_writer_block_burst: RTL and testbench
============================================

// Module: memory_writer_block_burst
// PURPOSE
//  AXI write master for the output side of the frame pipeline. It accepts a
//  pixel stream in block order: 8x8 blocks left-to-right, then top-to-bottom,
//  each block raster-scanned. It writes each block row back to frame memory
//  as one INCR burst. It is the write-side counterpart of the block-order
//  noise-estimation reader and uses the same block walk and address formula.
// PARAMETERS
//  ADDR_WIDTH  32  address width; address unit = one pixel word
//  DATA_WIDTH  32  pixel word width
//  BLOCK_SIZE  8   block edge (power of 2, <=8); burst length in beats
// PORTS
//  clk           in   1    clock
//  rst_n         in   1    async active-low reset
//  frame_height  in   16   rows, multiple of BLOCK_SIZE, <=720, latched on frame_start
//  frame_width   in   16   cols, multiple of BLOCK_SIZE, <=1280, latched on frame_start
//  base_addr_in  in   AW   frame base address, latched on frame_start
//  frame_start   in   1    1-cycle pulse; starts a frame when idle
//  pixel_in      in   DW   input pixel, block order
//  pixel_valid   in   1    pixel_in valid
//  pixel_ready   out  1    pixel accepted when valid&&ready
//  awaddr        out  AW   burst start address
//  awlen         out  8    BLOCK_SIZE-1 (AXI4 encoding)
//  awsize        out  3    3'd2; awburst out 2: 2'd1 (INCR)
//  awvalid/awready  out/in  1  AW handshake
//  wdata         out  DW   beat data
//  wvalid/wready    out/in  1  W handshake
//  wlast         out  1    high on beat BLOCK_SIZE-1 of each burst
//  bvalid/bready    in/out  1  B handshake; bresp in 2
//  busy          out  1    high from accepted frame_start to frame_done
//  frame_done    out  1    1-cycle pulse after the last B response of a frame
// BEHAVIOUR
//  Reset: outputs 0 except awlen, awsize, awburst (constants). FIFO is empty.
//  Counters (px_y, col_blk, row_blk) are 0. State is IDLE.
//  Input: fifo depth 2*BLOCK_SIZE. pixel_ready = busy && !fifo_full.
//   Pixels arriving when not busy are not accepted.
//  FSM:
//   IDLE  -> ADDR when frame_start; latch dims/base, busy<=1.
//   ADDR  -> awvalid=1 once fifo_count>=BLOCK_SIZE; hold awaddr stable until
//            awready. Then -> DATA.
//   DATA  -> wvalid=1 while beats remain (fifo holds >=1); pop on wready.
//            wlast on beat BLOCK_SIZE-1. On last beat accepted -> RESP.
//   RESP  -> bready=1. On bvalid: if last burst of frame -> DONE,
//            else advance counters and -> ADDR.
//   DONE  -> frame_done=1 for one cycle, busy<=0 -> IDLE.
//  Exactly one burst is outstanding at a time. The AW handshake is never
//   issued before 8 words are buffered, so wvalid never drops inside a burst.
//  Address: awaddr = base + (row_blk*BS+px_y)*width + col_blk*BS.
//   Compute it one cycle ahead into a registered holder (the multiply is off
//   the AW path).
//  Counter walk: px_y wraps at BS-1 -> col_blk++. col_blk wraps at
//   width/BS-1 -> row_blk++. Last burst: all three at max.
//  Arithmetic: width*row computed in ADDR_WIDTH bits. The result is
//   truncated; no overflow check.
//  Simultaneous events:
//   - push and pop in the same cycle: fifo_count unchanged.
//   - frame_start while busy: ignored.
//  Stalls: wready=0 holds wdata/wlast; awready=0 holds awaddr.
//  Reset mid-burst: everything returns to reset values immediately. The
//   partial burst is abandoned; the interconnect is reset alongside.
// CONFIGURATION
//  MEM_WRITER_BRESP_CHECK_EN defined:
//   - adds output wr_error (1 bit, sticky).
//   - set when bvalid&&bready&&bresp!=2'b00.
//   - cleared on an accepted frame_start. The frame continues regardless.
//  Undefined: bresp is ignored and there is no wr_error port.
// STRUCTURE
//  Shared package frame_pipe_pkg:
//   - state enum wr_state_t {IDLE, ADDR, DATA, RESP, DONE}
//   - AXI constants BURST_INCR=2'd1, SIZE_4B=3'd2, RESP_OKAY=2'b00
//   - MAX_WIDTH=1280, MAX_HEIGHT=720
//  Sub-module: burst_sync_fifo (DEPTH=2*BLOCK_SIZE, WIDTH=DATA_WIDTH) with
//   count output. The FSM, counters and address holder live in the top.
// TESTING
//  1. 16x16 frame, base 0x1000, always ready:
//     expect 32 bursts; awaddr 0x1000, 0x1010 .. 0x1070, then 0x1008.
//     Last awaddr is 0x10F8. frame_done is 1 pulse.
//  2. Pixel values = index 0..255: memory model holds block-reassembled
//     raster image; mem[0x1008] = pixel 64.
//  3. wready toggles 1/0 per cycle:
//     wdata/wlast held during stalls; wlast on beat 7 only; 8 beats per burst.
//  4. bvalid delayed 20 cycles:
//     no second awvalid before the B handshake; pixel_ready drops after 16
//     buffered words.
//  5. frame_start pulsed mid-frame: ignored. rst_n low mid-DATA:
//     awvalid, wvalid and busy are 0 the same cycle; the next frame_start
//     runs clean.
//  6. With MEM_WRITER_BRESP_CHECK_EN, bresp=2'b10 on burst 3:
//     wr_error=1 through frame_done; it clears on the next frame_start.

Source files
------------

// File: rtl/frame_pipe_pkg.sv
// Shared types and constants for the frame pipeline.
// Holds the write FSM state enum, AXI encodings and frame limits.
package frame_pipe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        RESP,
        DONE
    } wr_state_t;

    localparam logic [1:0] BURST_INCR = 2'd1;
    localparam logic [2:0] SIZE_4B    = 3'd2;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int MAX_WIDTH  = 1280;
    localparam int MAX_HEIGHT = 720;

    // Index of the last block along one frame dimension.
    function automatic logic [15:0] last_blk(
        input logic [15:0] dim,
        input int          blk_log2
    );
        return (dim >> blk_log2) - 16'd1;
    endfunction

endpackage

// File: rtl/burst_sync_fifo.sv
// Single-clock FIFO buffering pixels ahead of the AXI write bursts.
// Ports: clk, rst_n, push_i/din_i, pop_i/dout_o (show-ahead),
// count_o (occupancy), full_o, empty_o. DEPTH must be a power of 2.
module burst_sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // Simultaneous push and pop leave the occupancy unchanged.
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only occupied entries are ever read out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/memory_writer_block_burst.sv
// AXI write master: takes pixels in 8x8-block order and writes each
// block row back to frame memory as one INCR burst of BLOCK_SIZE beats.
// Ports: clk/rst_n; frame_height/frame_width/base_addr_in/frame_start
// (latched on start); pixel_in/pixel_valid/pixel_ready stream in;
// AXI AW (awaddr/awlen/awsize/awburst/awvalid/awready), W (wdata/
// wvalid/wready/wlast), B (bvalid/bready/bresp); busy, frame_done.
// Option MEM_WRITER_BRESP_CHECK_EN adds sticky wr_error on non-OKAY bresp.
module memory_writer_block_burst
    import frame_pipe_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           frame_height,
    input  logic [15:0]           frame_width,
    input  logic [ADDR_WIDTH-1:0] base_addr_in,
    input  logic                  frame_start,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  pixel_valid,
    output logic                  pixel_ready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    output logic                  wlast,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  busy,
    output logic                  frame_done
`ifdef MEM_WRITER_BRESP_CHECK_EN
    ,
    output logic                  wr_error
`endif
);

    localparam int AW      = ADDR_WIDTH;
    localparam int DEPTH   = 2 * BLOCK_SIZE;
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int BS_LOG2 = $clog2(BLOCK_SIZE);

    localparam logic [3:0] PX_MAX    = 4'(BLOCK_SIZE - 1);
    localparam logic [3:0] BEAT_LAST = 4'(BLOCK_SIZE - 1);

    wr_state_t       state_q, state_d;
    logic            busy_q, busy_d;
    logic [15:0]     width_q, width_d;
    logic [15:0]     col_max_q, col_max_d;
    logic [15:0]     row_max_q, row_max_d;
    logic [15:0]     col_blk_q, col_blk_d;
    logic [15:0]     row_blk_q, row_blk_d;
    logic [3:0]      px_y_q, px_y_d;
    logic [3:0]      beat_q, beat_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW-1:0]   addr_q, addr_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    logic start_ok;
    logic last_burst;
    logic b_fire;

    assign awlen   = 8'(BLOCK_SIZE - 1);
    assign awsize  = SIZE_4B;
    assign awburst = BURST_INCR;

    assign busy        = busy_q;
    assign pixel_ready = busy_q && !fifo_full;
    assign fifo_push   = pixel_valid && pixel_ready;
    assign fifo_pop    = wvalid && wready;

    assign awaddr = addr_q;
    assign wdata  = wvalid ? fifo_dout : '0;
    assign wlast  = wvalid && (beat_q == BEAT_LAST);

    assign start_ok   = frame_start && (state_q == IDLE);
    assign b_fire     = bvalid && bready;
    assign last_burst = (px_y_q == PX_MAX)
                     && (col_blk_q == col_max_q)
                     && (row_blk_q == row_max_q);

    burst_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .din_i   (pixel_in),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        width_d   = width_q;
        col_max_d = col_max_q;
        row_max_d = row_max_q;
        col_blk_d = col_blk_q;
        row_blk_d = row_blk_q;
        px_y_d    = px_y_q;
        beat_d    = beat_q;
        base_d    = base_q;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d   = ADDR;
                    busy_d    = 1'b1;
                    width_d   = frame_width;
                    col_max_d = last_blk(frame_width, BS_LOG2);
                    row_max_d = last_blk(frame_height, BS_LOG2);
                    base_d    = base_addr_in;
                    col_blk_d = '0;
                    row_blk_d = '0;
                    px_y_d    = '0;
                    beat_d    = '0;
                end
            end
            ADDR: begin
                // A full burst is buffered before AW goes out, so the
                // W channel can never run dry mid-burst.
                awvalid = (fifo_count >= CW'(BLOCK_SIZE));
                if (awvalid && awready) begin
                    state_d = DATA;
                    beat_d  = '0;
                end
            end
            DATA: begin
                wvalid = !fifo_empty;
                if (wvalid && wready) begin
                    beat_d = beat_q + 4'd1;
                    if (beat_q == BEAT_LAST) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    if (last_burst) begin
                        state_d = DONE;
                    end else begin
                        state_d = ADDR;
                        if (px_y_q != PX_MAX) begin
                            px_y_d = px_y_q + 4'd1;
                        end else begin
                            px_y_d = '0;
                            if (col_blk_q != col_max_q) begin
                                col_blk_d = col_blk_q + 16'd1;
                            end else begin
                                col_blk_d = '0;
                                row_blk_d = row_blk_q + 16'd1;
                            end
                        end
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next burst address from next-state counters: registered so the
    // multiply never sits between the counters and awaddr.
    assign addr_d = base_d
                  + (AW'(row_blk_d) * AW'(BLOCK_SIZE) + AW'(px_y_d))
                    * AW'(width_d)
                  + AW'(col_blk_d) * AW'(BLOCK_SIZE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            width_q   <= '0;
            col_max_q <= '0;
            row_max_q <= '0;
            col_blk_q <= '0;
            row_blk_q <= '0;
            px_y_q    <= '0;
            beat_q    <= '0;
            base_q    <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            width_q   <= width_d;
            col_max_q <= col_max_d;
            row_max_q <= row_max_d;
            col_blk_q <= col_blk_d;
            row_blk_q <= row_blk_d;
            px_y_q    <= px_y_d;
            beat_q    <= beat_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
        end
    end

`ifdef MEM_WRITER_BRESP_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if (b_fire && (bresp != RESP_OKAY)) begin
            err_q <= 1'b1;
        end
    end

    assign wr_error = err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{bresp, b_fire, start_ok};
`endif

endmodule

// File: tb/tb_memory_writer_block_burst.sv
// Directed bench for memory_writer_block_burst with an AXI slave model
// and a block-to-raster reference image. Optional MEM_WRITER_BRESP_CHECK_EN.
module tb_memory_writer_block_burst;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] frame_height;
    logic [15:0] frame_width;
    logic [31:0] base_addr_in;
    logic        frame_start;
    logic [31:0] pixel_in = '0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready = 1'b0;
    logic        wlast;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [1:0]  bresp = 2'b00;
    logic        busy;
    logic        frame_done;
`ifdef MEM_WRITER_BRESP_CHECK_EN
    logic        wr_error;
    logic        err_at_done = 1'b0;
`endif

    always #5 clk = ~clk;

    memory_writer_block_burst dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_height (frame_height),
        .frame_width  (frame_width),
        .base_addr_in (base_addr_in),
        .frame_start  (frame_start),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .awaddr       (awaddr),
        .awlen        (awlen),
        .awsize       (awsize),
        .awburst      (awburst),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wvalid       (wvalid),
        .wready       (wready),
        .wlast        (wlast),
        .bvalid       (bvalid),
        .bready       (bready),
        .bresp        (bresp),
        .busy         (busy),
        .frame_done   (frame_done)
`ifdef MEM_WRITER_BRESP_CHECK_EN
        ,
        .wr_error     (wr_error)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] mem [logic [31:0]];
    logic [31:0] aw_log [64];
    logic [31:0] cur_addr = '0;
    logic [31:0] prev_wdata = '0;
    logic [31:0] prev_awaddr = '0;
    logic        prev_wlast = 1'b0;
    int aw_count = 0;
    int beat = 0;
    int beats_total = 0;
    int feed_idx = 0;
    int feed_base = 0;
    int done_cnt = 0;
    int stall_cnt = 0;
    int bdelay = 0;
    int bcnt = 0;
    int err_burst = -1;
    bit outstanding = 0;
    bit pending = 0;
    bit b_fire = 0;
    bit wtoggle = 0;
    bit feed_on = 0;
    bit saw_full = 0;
    bit stall_prev = 0;
    bit aw_stall_prev = 0;

    // Pixel source, AXI slave and monitors; acts mid-cycle and
    // predicts which handshakes complete at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            bvalid = 0;
            pending = 0;
            b_fire = 0;
            outstanding = 0;
            beat = 0;
            pixel_valid = 0;
            feed_on = 0;
            stall_prev = 0;
            aw_stall_prev = 0;
        end else begin
            if (b_fire) begin
                bvalid = 0;
                outstanding = 0;
                b_fire = 0;
            end
            if (stall_prev) begin
                chk("hold_wdata", wdata, prev_wdata);
                chk("hold_wlast", wlast, prev_wlast);
            end
            if (aw_stall_prev) begin
                chk("hold_awaddr", awaddr, prev_awaddr);
            end
            wready = wtoggle ? ~wready : 1'b1;
            awready = wtoggle ? ~awready : 1'b1;
            if (feed_on && feed_idx < 256) begin
                pixel_valid = 1;
                pixel_in = 32'(feed_base + feed_idx);
                if (busy && !pixel_ready) begin
                    chk("fifo_full16", feed_idx - beats_total, 16);
                    saw_full = 1;
                end
                if (pixel_ready) feed_idx++;
            end else begin
                pixel_valid = 0;
            end
            if (awvalid) begin
                chk("one_outstanding", outstanding, 0);
                if (awready) begin
                    if (aw_count > 0) chk("beats8", beat, 8);
                    if (aw_count < 64) aw_log[aw_count] = awaddr;
                    cur_addr = awaddr;
                    aw_count++;
                    outstanding = 1;
                    beat = 0;
                end
            end
            if (pending) begin
                if (bcnt == 0) begin
                    bvalid = 1;
                    bresp = (aw_count - 1 == err_burst) ? 2'b10 : 2'b00;
                    pending = 0;
                end else begin
                    bcnt--;
                end
            end
            if (wvalid && wready) begin
                mem[cur_addr + 32'(beat)] = wdata;
                chk("wlast_pos", wlast, beat == 7);
                if (beat == 7) begin
                    pending = 1;
                    bcnt = bdelay;
                end
                beat++;
                beats_total++;
            end
            stall_prev = wvalid && !wready;
            if (stall_prev) stall_cnt++;
            prev_wdata = wdata;
            prev_wlast = wlast;
            aw_stall_prev = awvalid && !awready;
            prev_awaddr = awaddr;
            b_fire = bvalid && bready;
            if (frame_done) begin
                done_cnt++;
                chk("beats8_last", beat, 8);
`ifdef MEM_WRITER_BRESP_CHECK_EN
                err_at_done = wr_error;
`endif
            end
        end
    end

    task automatic start_frame(input logic [31:0] base,
                               input int pbase);
        @(posedge clk);
        #1;
        mem.delete();
        aw_count = 0;
        beats_total = 0;
        feed_idx = 0;
        feed_base = pbase;
        feed_on = 1;
        frame_width = 16;
        frame_height = 16;
        base_addr_in = base;
        frame_start = 1;
        @(posedge clk);
        #1;
        frame_start = 0;
    endtask

    task automatic wait_done(input int n, input string tag);
        int k = 0;
        while (done_cnt <= n && k < 8000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(tag, done_cnt, n + 1);
    endtask

    // Block-order pixel p lands at raster (y, x) of the 16x16 frame.
    task automatic check_image(input int pbase, input string tag);
        int bad = 0;
        int b, r, c, y, x;
        logic [31:0] a, v;
        for (int p = 0; p < 256; p++) begin
            b = p / 64;
            r = (p % 64) / 8;
            c = p % 8;
            y = (b / 2) * 8 + r;
            x = (b % 2) * 8 + c;
            a = 32'h1000 + 32'(y * 16 + x);
            v = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
            if (v != 32'(pbase + p)) bad++;
        end
        chk(tag, bad, 0);
        chk({tag, "_words"}, mem.num(), 256);
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        frame_start = 0;
        frame_width = 0;
        frame_height = 0;
        base_addr_in = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pixel_ready", pixel_ready, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_awlen", awlen, 7);
        chk("rst_awsize", awsize, 2);
        chk("rst_awburst", awburst, 1);
        rst_n = 1;

        start_frame(32'h1000, 0);
        chk("t1_busy", busy, 1);
        wait_done(0, "t1_done");
        repeat (5) @(posedge clk);
        #1;
        chk("t1_done_pulse", done_cnt, 1);
        chk("t1_idle", busy, 0);
        chk("t1_bursts", aw_count, 32);
        chk("t1_aw0", aw_log[0], 32'h1000);
        chk("t1_aw1", aw_log[1], 32'h1010);
        chk("t1_aw7", aw_log[7], 32'h1070);
        chk("t1_aw8", aw_log[8], 32'h1008);
        chk("t1_aw16", aw_log[16], 32'h1080);
        chk("t1_aw31", aw_log[31], 32'h10F8);
        check_image(0, "t2_image");
        chk("t2_mem1008", rd(32'h1008), 64);

        stall_cnt = 0;
        wtoggle = 1;
        start_frame(32'h1000, 1000);
        wait_done(1, "t3_done");
        wtoggle = 0;
        chk("t3_bursts", aw_count, 32);
        chk("t3_stalled", stall_cnt > 0, 1);
        check_image(1000, "t3_image");

        bdelay = 20;
        saw_full = 0;
        start_frame(32'h1000, 2000);
        wait_done(2, "t4_done");
        bdelay = 0;
        chk("t4_saw_full", saw_full, 1);
        chk("t4_bursts", aw_count, 32);
        check_image(2000, "t4_image");

        start_frame(32'h1000, 3000);
        for (int k = 0; k < 2000 && aw_count < 3; k++) begin
            @(posedge clk);
            #1;
        end
        chk("t5_reach_b3", aw_count >= 3, 1);
        frame_start = 1;
        base_addr_in = 32'h8000;
        frame_width = 32;
        @(posedge clk);
        #1;
        frame_start = 0;
        chk("t5_still_busy", busy, 1);
        wait_done(3, "t5_done");
        chk("t5_bursts", aw_count, 32);
        chk("t5_aw31", aw_log[31], 32'h10F8);
        check_image(3000, "t5_image");

        start_frame(32'h1000, 4000);
        for (int k = 0; k < 2000 && !(wvalid && aw_count >= 2); k++) begin
            @(posedge clk);
            #1;
        end
        chk("t5_in_data", wvalid, 1);
        @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        chk("t5_rst_awvalid", awvalid, 0);
        chk("t5_rst_wvalid", wvalid, 0);
        chk("t5_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        start_frame(32'h1000, 5000);
        wait_done(4, "t5_clean_done");
        chk("t5_clean_bursts", aw_count, 32);
        chk("t5_clean_aw0", aw_log[0], 32'h1000);
        check_image(5000, "t5_clean_image");

`ifdef MEM_WRITER_BRESP_CHECK_EN
        err_burst = 3;
        start_frame(32'h1000, 6000);
        chk("t6_err_start", wr_error, 0);
        wait_done(5, "t6_done");
        err_burst = -1;
        chk("t6_err_at_done", err_at_done, 1);
        chk("t6_err_sticky", wr_error, 1);
        check_image(6000, "t6_image");
        start_frame(32'h1000, 7000);
        chk("t6_err_cleared", wr_error, 0);
        wait_done(6, "t6_done2");
        chk("t6_err_clean", err_at_done, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
